// File: rtl/ddr_port_responder_if.sv
`default_nettype none
// ddr_port_responder_if: word-serial read/write/refresh request port.
// master = client (display row buffer), slave = memory-side responder.
interface ddr_port_responder_if;
  logic        read;
  logic [23:0] readAddress;
  logic        readAcknowledge;
  logic [15:0] readData;
  logic        write;
  logic [23:0] writeAddress;
  logic [15:0] writeData;
  logic        writeAcknowledge;
  logic        refresh;
  logic        busy;
  logic [15:0] refreshCount;

  modport master (
    output read, readAddress, write, writeAddress, writeData, refresh,
    input  readAcknowledge, readData, writeAcknowledge, busy, refreshCount
  );

  modport slave (
    input  read, readAddress, write, writeAddress, writeData, refresh,
    output readAcknowledge, readData, writeAcknowledge, busy, refreshCount
  );
endinterface
`default_nettype wire

// File: rtl/ddr_port_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ddr_port_responder: block-RAM responder for the word-serial DDR port,    |
// | with modelled refresh stalls.                        Revision: 1.0       |
// +--------------------------------------------------------------------------+
module ddr_port_responder #(
  parameter int MEM_AW         = 14,
  parameter int ACCESS_LATENCY = 3,
  parameter int REFRESH_CYCLES = 8
) (
  input logic                 clk133_p,
  input logic                 rst,
  ddr_port_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_ACCESS = 2'd1,
    RD_ACCESS = 2'd2,
    REFRESH   = 2'd3
  } state_t;

  localparam logic [7:0] C_ACCESS_LOAD  = 8'(ACCESS_LATENCY);
  localparam logic [7:0] C_REFRESH_LOAD = 8'(REFRESH_CYCLES);
  localparam int         C_DEPTH        = 1 << MEM_AW;

  state_t              r_state;
  logic [7:0]          r_count;
  logic [MEM_AW-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic                r_pending;
  logic                r_rd_ack;
  logic                r_wr_ack;
  logic [15:0]         r_rd_data;
  logic [15:0]         r_refresh_count;
  logic [15:0]         r_mem [C_DEPTH];

  logic                w_last;
  logic                w_commit;
  logic                w_fetch;
  logic                w_refresh_done;
  logic                w_count_inc;
  logic                w_unused_addr_hi;

  assign w_last         = (r_count == 8'd1);
  assign w_commit       = (r_state == WR_ACCESS) && bus.write && w_last;
  assign w_fetch        = (r_state == RD_ACCESS) && bus.read && w_last;
  assign w_refresh_done = (r_state == REFRESH) && w_last;
  assign w_count_inc    = w_refresh_done && (r_refresh_count != 16'hFFFF);

  // Upper address bits are deliberately ignored: addresses alias modulo the RAM depth.
  assign w_unused_addr_hi = ^{bus.readAddress[23:MEM_AW], bus.writeAddress[23:MEM_AW]};

  // RAM contents survive reset; only the commit is suppressed while rst is low.
  always_ff @(posedge clk133_p) begin
    if (rst && w_commit) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  always_ff @(posedge clk133_p) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_count         <= 8'd0;
      r_addr          <= '0;
      r_wdata         <= 16'd0;
      r_pending       <= 1'b0;
      r_rd_ack        <= 1'b0;
      r_wr_ack        <= 1'b0;
      r_rd_data       <= 16'd0;
      r_refresh_count <= 16'd0;
    end else begin
      r_rd_ack        <= 1'b0;
      r_wr_ack        <= 1'b0;
      r_refresh_count <= r_refresh_count + {15'd0, w_count_inc};

      if (bus.refresh && (r_state != REFRESH)) begin
        r_pending <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          // Clearing on entry wins over a refresh sampled at the same edge.
          if (r_pending) begin
            r_state   <= REFRESH;
            r_count   <= C_REFRESH_LOAD;
            r_pending <= 1'b0;
          end else if (bus.write) begin
            r_state <= WR_ACCESS;
            r_count <= C_ACCESS_LOAD;
            r_addr  <= bus.writeAddress[MEM_AW-1:0];
            r_wdata <= bus.writeData;
          end else if (bus.read) begin
            r_state <= RD_ACCESS;
            r_count <= C_ACCESS_LOAD;
            r_addr  <= bus.readAddress[MEM_AW-1:0];
          end
        end

        WR_ACCESS: begin
          if (!bus.write) begin
            r_state <= IDLE;
          end else if (w_last) begin
            r_wr_ack <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_count <= r_count - 8'd1;
          end
        end

        RD_ACCESS: begin
          if (!bus.read) begin
            r_state <= IDLE;
          end else if (w_last) begin
            r_rd_data <= r_mem[r_addr];
            r_rd_ack  <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_count <= r_count - 8'd1;
          end
        end

        REFRESH: begin
          if (w_last) begin
            r_state <= IDLE;
          end else begin
            r_count <= r_count - 8'd1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.readAcknowledge  = r_rd_ack;
  assign bus.writeAcknowledge = r_wr_ack;
  assign bus.readData         = r_rd_data;
  assign bus.busy             = (r_state != IDLE);
  assign bus.refreshCount     = r_refresh_count;

endmodule
`default_nettype wire
